// File: rtl/merge_pkg.sv
// Shared types for the merge tree output packer.
// Byte/word geometry, packer state and the buffered word record.
package merge_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } pk_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  nbytes;
    } word_t;

endpackage

// File: rtl/merge_word_fifo.sv
// First-word-fall-through FIFO of packed words.
// Level comes from pointers carrying one extra wrap bit.
module merge_word_fifo
    import merge_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  word_t         wr,
    input  logic          pop,
    output word_t         rd,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    word_t         mem [DEPTH];
    logic [LW-1:0] wp;
    logic [LW-1:0] rp;
    logic          do_pop;
    logic          do_push;

    assign level   = wp - rp;
    assign empty   = (wp == rp);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a word when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);
    assign rd      = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wr;
    end

endmodule

// File: rtl/merge_out_packer.sv
// Packs the merge tree byte stream into 32-bit words for the host sink.
// Partial words leave on flush or idle timeout; dropped words are counted.
module merge_out_packer
    import merge_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int AFULL_MARGIN  = 2,
    localparam int LW = $clog2(FIFO_DEPTH) + 1,
    localparam int TW = $clog2(FLUSH_TIMEOUT)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid,
    input  logic [7:0]    i_data,
    output logic          o_ren,
    input  logic          i_flush,
    output logic          o_wvalid,
    input  logic          i_wready,
    output logic [31:0]   o_wdata,
    output logic [2:0]    o_wbytes,
    output logic [LW-1:0] o_level,
    output logic          o_overflow,
    output logic [15:0]   o_drop_cnt,
    input  logic          i_clr_ovf
);

    pk_state_t   state;
    logic [1:0]  idx;
    logic [23:0] lanes;
    logic [TW-1:0] timer;

    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        drop;
    logic        tmo;
    logic [31:0] byte_sh;
    word_t       wr_word;
    word_t       rd_word;

    // Lanes above idx are always zero, so OR-ing the new byte in is safe.
    assign byte_sh = 32'(i_data) << {idx, 3'b000};
    assign wr_word.data   = {8'h00, lanes} | (i_valid ? byte_sh : 32'h0);
    assign wr_word.nbytes = {1'b0, idx} + {2'b00, i_valid};

    assign tmo  = (state == FILL) & ~i_valid
                & (timer == TW'(FLUSH_TIMEOUT - 1));
    assign push = (i_valid & (idx == 2'd3))
                | (i_flush & ((state == FILL) | i_valid))
                | tmo;

    assign pop  = o_wvalid & i_wready;
    assign drop = push & full & ~pop;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            idx   <= '0;
            lanes <= '0;
            timer <= '0;
        end else if (push) begin
            state <= IDLE;
            idx   <= '0;
            lanes <= '0;
            timer <= '0;
        end else if (i_valid) begin
            state <= FILL;
            idx   <= idx + 1'b1;
            lanes <= wr_word.data[23:0];
            timer <= '0;
        end else if (state == FILL) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else if (i_clr_ovf) begin
            o_overflow <= drop;
            o_drop_cnt <= {15'd0, drop};
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

    merge_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (push),
        .wr    (wr_word),
        .pop   (pop),
        .rd    (rd_word),
        .level (o_level),
        .full  (full),
        .empty (empty)
    );

    assign o_wvalid = ~empty;
    assign o_wdata  = rd_word.data;
    assign o_wbytes = rd_word.nbytes;
    assign o_ren    = (o_level < LW'(FIFO_DEPTH - AFULL_MARGIN));

endmodule

// File: tb/tb_merge_out_packer.sv
// Bench for merge_out_packer: vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_merge_out_packer;

    localparam int DEPTH  = 8;
    localparam int TMO    = 16;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic [7:0]  data;
    logic        ren;
    logic        flush;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [2:0]  wbytes;
    logic [3:0]  level;
    logic        ovf;
    logic [15:0] dcnt;
    logic        clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    merge_out_packer #(
        .FIFO_DEPTH    (DEPTH),
        .FLUSH_TIMEOUT (TMO),
        .AFULL_MARGIN  (MARGIN)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_valid    (valid),
        .i_data     (data),
        .o_ren      (ren),
        .i_flush    (flush),
        .o_wvalid   (wvalid),
        .i_wready   (wready),
        .o_wdata    (wdata),
        .o_wbytes   (wbytes),
        .o_level    (level),
        .o_overflow (ovf),
        .o_drop_cnt (dcnt),
        .i_clr_ovf  (clr)
    );

    typedef struct {
        logic [31:0] data;
        int          nbytes;
    } mword_t;

    logic [7:0] pb[$];
    mword_t     fq[$];
    int         idle;
    bit         m_ovf;
    int         m_cnt;

    function automatic void check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        pb.delete();
        fq.delete();
        idle  = 0;
        m_ovf = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_step();
        bit     push = 0;
        bit     pop;
        bit     full;
        bit     dropped;
        mword_t w;
        pop  = (fq.size() > 0) && wready;
        full = (fq.size() == DEPTH);
        if (valid) begin
            pb.push_back(data);
            idle = 0;
        end else if (pb.size() > 0) begin
            idle++;
        end
        if (pb.size() == 4 || (flush && pb.size() > 0) || idle == TMO) begin
            w.data = 0;
            foreach (pb[k]) w.data |= 32'(pb[k]) << (8 * k);
            w.nbytes = pb.size();
            push = 1;
            pb.delete();
            idle = 0;
        end
        dropped = push && full && !pop;
        if (pop) void'(fq.pop_front());
        if (push && !dropped) fq.push_back(w);
        if (clr) begin
            m_ovf = dropped;
            m_cnt = dropped ? 1 : 0;
        end else if (dropped) begin
            m_ovf = 1;
            if (m_cnt < 65535) m_cnt++;
        end
    endfunction

    function automatic void check_all();
        check("wvalid", wvalid, fq.size() > 0);
        if (fq.size() > 0) begin
            check("wdata", wdata, fq[0].data);
            check("wbytes", wbytes, fq[0].nbytes);
        end
        check("level", level, fq.size());
        check("ren", ren, fq.size() < DEPTH - MARGIN);
        check("overflow", ovf, m_ovf);
        check("drop_cnt", dcnt, m_cnt);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(bit v, logic [7:0] d, bit f);
        valid = v;
        data  = d;
        flush = f;
        cycle();
        valid = 0;
        flush = 0;
    endtask

    task automatic push_words(int n);
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                drive(1, 8'($urandom), 0);
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          f;
        bit          ev;
        logic [31:0] ew;
        logic [2:0]  eb;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1, 8'h11, 0, 0, 32'h0, 3'd0};
        tbl[1]  = '{1, 8'h22, 0, 0, 32'h0, 3'd0};
        tbl[2]  = '{1, 8'h33, 0, 0, 32'h0, 3'd0};
        tbl[3]  = '{1, 8'h44, 0, 1, 32'h44332211, 3'd4};
        tbl[4]  = '{0, 8'h00, 0, 0, 32'h0, 3'd0};
        tbl[5]  = '{1, 8'h01, 0, 0, 32'h0, 3'd0};
        tbl[6]  = '{1, 8'h02, 1, 1, 32'h00000201, 3'd2};
        tbl[7]  = '{0, 8'h00, 1, 0, 32'h0, 3'd0};
        tbl[8]  = '{0, 8'h00, 1, 0, 32'h0, 3'd0};
        tbl[9]  = '{1, 8'hAA, 0, 0, 32'h0, 3'd0};
        tbl[10] = '{1, 8'hBB, 0, 0, 32'h0, 3'd0};
        tbl[11] = '{1, 8'hCC, 1, 1, 32'h00CCBBAA, 3'd3};
        tbl[12] = '{0, 8'h00, 0, 0, 32'h0, 3'd0};
        tbl[13] = '{1, 8'h01, 0, 0, 32'h0, 3'd0};
        tbl[14] = '{1, 8'h02, 0, 0, 32'h0, 3'd0};
        tbl[15] = '{1, 8'h03, 0, 0, 32'h0, 3'd0};
        tbl[16] = '{1, 8'h04, 1, 1, 32'h04030201, 3'd4};
        tbl[17] = '{0, 8'h00, 0, 0, 32'h0, 3'd0};

        rstn   = 0;
        valid  = 0;
        data   = 0;
        flush  = 0;
        wready = 1;
        clr    = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1;
        check("rst_wvalid", wvalid, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wbytes", wbytes, 0);
        check("rst_level", level, 0);
        check("rst_ren", ren, 1);
        check("rst_ovf", ovf, 0);
        check("rst_cnt", dcnt, 0);

        // vector table: pack, flush, flush in IDLE, flush with 4th byte
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].f);
            check($sformatf("tbl%0d_wvalid", i), wvalid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_wdata", i), wdata, tbl[i].ew);
                check($sformatf("tbl%0d_wbytes", i), wbytes, tbl[i].eb);
            end
        end

        // timeout fires after the 16th idle cycle
        drive(1, 8'hAA, 0);
        drive(1, 8'hBB, 0);
        for (int i = 0; i < TMO - 1; i++) begin
            drive(0, 8'h00, 0);
            check("tmo_early", wvalid, 0);
        end
        drive(0, 8'h00, 0);
        check("tmo_wvalid", wvalid, 1);
        check("tmo_wdata", wdata, 32'h0000BBAA);
        check("tmo_wbytes", wbytes, 2);
        drive(0, 8'h00, 0);

        // 15 idle cycles then a byte: word continues
        drive(1, 8'hAA, 0);
        drive(1, 8'hBB, 0);
        repeat (TMO - 1) drive(0, 8'h00, 0);
        drive(1, 8'hCC, 0);
        check("tmo_none", wvalid, 0);
        drive(1, 8'hDD, 0);
        check("cont_wdata", wdata, 32'hDDCCBBAA);
        check("cont_wbytes", wbytes, 4);
        drive(0, 8'h00, 0);

        // backpressure and overflow
        wready = 0;
        push_words(9);
        check("bp_level", level, 8);
        check("bp_ren", ren, 0);
        check("bp_ovf", ovf, 1);
        check("bp_cnt", dcnt, 1);
        wready = 1;
        repeat (9) drive(0, 8'h00, 0);
        check("drain_level", level, 0);
        clr = 1;
        drive(0, 8'h00, 0);
        clr = 0;
        check("clr_ovf", ovf, 0);
        check("clr_cnt", dcnt, 0);

        // full FIFO with a pop on the completing edge
        wready = 0;
        push_words(8);
        for (int b = 0; b < 3; b++) drive(1, 8'($urandom), 0);
        wready = 1;
        drive(1, 8'h5A, 0);
        wready = 0;
        check("fullpop_level", level, 8);
        check("fullpop_ovf", ovf, 0);

        // clear coinciding with a drop
        for (int b = 0; b < 3; b++) drive(1, 8'($urandom), 0);
        clr = 1;
        drive(1, 8'hA5, 0);
        clr = 0;
        check("clrdrop_ovf", ovf, 1);
        check("clrdrop_cnt", dcnt, 1);
        wready = 1;
        repeat (9) drive(0, 8'h00, 0);
        clr = 1;
        drive(0, 8'h00, 0);
        clr = 0;

        // randomized traffic in phases of differing byte density
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                int pv;
                pv = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 4 : 60;
                valid  = ($urandom_range(0, 99) < pv);
                data   = 8'($urandom);
                flush  = ($urandom_range(0, 99) < 3);
                wready = ($urandom_range(0, 99) < ((ph == 3) ? 20 : 60));
                clr    = ($urandom_range(0, 99) < 2);
                cycle();
            end
        end
        valid  = 0;
        flush  = 0;
        clr    = 0;
        wready = 1;
        repeat (DEPTH + TMO + 2) cycle();

        // reset in the middle of a word
        drive(1, 8'h91, 0);
        drive(1, 8'h92, 0);
        drive(1, 8'h93, 0);
        #2 rstn = 0;
        model_reset();
        #1;
        check("mid_rst_wvalid", wvalid, 0);
        check("mid_rst_wdata", wdata, 0);
        check("mid_rst_wbytes", wbytes, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_ren", ren, 1);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_cnt", dcnt, 0);
        @(negedge clk);
        rstn = 1;
        drive(1, 8'h01, 0);
        drive(1, 8'h02, 0);
        drive(1, 8'h03, 0);
        drive(1, 8'h04, 0);
        check("post_rst_wdata", wdata, 32'h04030201);
        check("post_rst_wbytes", wbytes, 4);
        drive(0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
